// File: rtl/shift_reg_sequencer_pkg.sv
// shift_seq_pkg: shared state encoding for the shift register run controller
package shift_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/shift_reg_sequencer_if.sv
// shift_reg_sequencer_if: control, status and shift-register link signals of the run controller
interface shift_reg_sequencer_if #(
    parameter int DIV_WIDTH   = 16,
    parameter int COUNT_WIDTH = 8
);

    logic                   start;
    logic                   stop;
    logic                   pause;
    logic [DIV_WIDTH-1:0]   divisor;
    logic [COUNT_WIDTH-1:0] target_periods;
    logic                   tc_in;
    logic                   ena_out;
    logic                   busy;
    logic                   done;
    logic [COUNT_WIDTH-1:0] periods_done;
    logic [1:0]             state_o;

    modport master (
        output start, stop, pause, divisor, target_periods, tc_in,
        input  ena_out, busy, done, periods_done, state_o
    );

    modport slave (
        input  start, stop, pause, divisor, target_periods, tc_in,
        output ena_out, busy, done, periods_done, state_o
    );

endinterface

// File: rtl/shift_reg_sequencer_prescaler.sv
// shift_seq_prescaler: rate counter 0..limit that wraps, with clear and advance enable
module shift_seq_prescaler #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstna,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] limit,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    assign tick = cnt_q == limit;

    // clear wins; otherwise advance only when enabled, wrapping after limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // count register
    always_ff @(posedge clk or negedge rstna) begin
        if (!rstna)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: paces the shift register enable and counts its period pulses
module shift_reg_sequencer
    import shift_seq_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstna,
    shift_reg_sequencer_if.slave  bus
);

    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [COUNT_WIDTH-1:0] tgt_q, tgt_d;
    logic [COUNT_WIDTH-1:0] per_q, per_d;
    logic                   clr;
    logic                   tick;
    logic                   tc_cnt;
    logic                   hit;

    shift_seq_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_pre (
        .clk   (clk),
        .rstna (rstna),
        .clr   (clr),
        .en    (state_q == ST_RUN),
        .limit (div_q),
        .tick  (tick)
    );

    assign tc_cnt           = bus.tc_in && (state_q == ST_RUN || state_q == ST_HOLD);
    assign hit              = tc_cnt && tgt_q != '0 && per_q + 1'b1 == tgt_q;
    assign bus.ena_out      = state_q == ST_RUN && tick;
    assign bus.busy         = state_q == ST_RUN || state_q == ST_HOLD;
    assign bus.done         = state_q == ST_DONE;
    assign bus.periods_done = per_q;
    assign bus.state_o      = state_q;

    // next state, config capture and saturating period count; stop outranks target and pause
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tgt_d   = tgt_q;
        per_d   = per_q;
        clr     = 1'b0;
        if (tc_cnt && !(&per_q))
            per_d = per_q + 1'b1;
        unique case (state_q)
            ST_IDLE: if (bus.start && !bus.stop) begin
                state_d = ST_RUN;
                div_d   = bus.divisor;
                tgt_d   = bus.target_periods;
                per_d   = '0;
                clr     = 1'b1;
            end
            ST_RUN:  state_d = bus.stop ? ST_IDLE : hit ? ST_DONE : bus.pause ? ST_HOLD : ST_RUN;
            ST_HOLD: state_d = bus.stop ? ST_IDLE : hit ? ST_DONE : bus.pause ? ST_HOLD : ST_RUN;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // state and configuration registers
    always_ff @(posedge clk or negedge rstna) begin
        if (!rstna) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            tgt_q   <= '0;
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tgt_q   <= tgt_d;
            per_q   <= per_d;
        end
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb_shift_reg_sequencer: vector table on a 2-bit-count instance, directed runs on an 8-bit one with an N=8 bouncing shift register
module tb_shift_reg_sequencer;
    import shift_seq_pkg::*;

    logic clk = 1'b0;
    logic rstna = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   ena_cnt = 0;
    int   pos = 0;
    logic up = 1'b1;

    shift_reg_sequencer_if #(.DIV_WIDTH(16), .COUNT_WIDTH(8)) b1 ();
    shift_reg_sequencer_if #(.DIV_WIDTH(16), .COUNT_WIDTH(2)) b2 ();

    shift_reg_sequencer #(.DIV_WIDTH(16), .COUNT_WIDTH(8)) u1 (.clk(clk), .rstna(rstna), .bus(b1.slave));
    shift_reg_sequencer #(.DIV_WIDTH(16), .COUNT_WIDTH(2)) u2 (.clk(clk), .rstna(rstna), .bus(b2.slave));

    always #5 clk = ~clk;

    // bouncing one-hot position 0..7; TC pulses the cycle after the enable that reaches the top end
    always @(posedge clk or negedge rstna) begin
        if (!rstna) begin
            pos      <= 0;
            up       <= 1'b1;
            b1.tc_in <= 1'b0;
        end else begin
            b1.tc_in <= 1'b0;
            if (b1.ena_out) begin
                if (up) begin
                    pos <= pos + 1;
                    if (pos == 6) begin
                        b1.tc_in <= 1'b1;
                        up       <= 1'b0;
                    end
                end else begin
                    pos <= pos - 1;
                    if (pos == 1) up <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) if (b1.ena_out) ena_cnt <= ena_cnt + 1;

    typedef struct packed {
        logic        start;
        logic        stop;
        logic        pause;
        logic [15:0] div;
        logic [1:0]  tgt;
        logic        tc;
        logic [1:0]  e_st;
        logic        e_ena;
        logic        e_busy;
        logic        e_done;
        logic [1:0]  e_per;
    } vec_t;

    vec_t v [20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rstna = 1'b0;
        b1.start = 0; b1.stop = 0; b1.pause = 0; b1.divisor = 0; b1.target_periods = 0;
        tick();
        tick();
        rstna = 1'b1;
    endtask

    task automatic go(input logic [15:0] d, input logic [7:0] t);
        b1.divisor = d;
        b1.target_periods = t;
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
    endtask

    initial begin
        int cyc, base, first, sp, bad;
        v[0]  = '{0,0,0,16'd0,2'd0,0, 2'd0,0,0,0,2'd0};
        v[1]  = '{1,1,0,16'd1,2'd0,0, 2'd0,0,0,0,2'd0};
        v[2]  = '{1,0,0,16'd1,2'd0,0, 2'd1,0,1,0,2'd0};
        v[3]  = '{0,0,0,16'd0,2'd0,1, 2'd1,1,1,0,2'd1};
        v[4]  = '{0,0,0,16'd0,2'd0,1, 2'd1,0,1,0,2'd2};
        v[5]  = '{0,0,0,16'd0,2'd0,1, 2'd1,1,1,0,2'd3};
        v[6]  = '{0,0,0,16'd0,2'd0,1, 2'd1,0,1,0,2'd3};
        v[7]  = '{0,0,1,16'd0,2'd0,1, 2'd2,0,1,0,2'd3};
        v[8]  = '{0,0,1,16'd0,2'd0,0, 2'd2,0,1,0,2'd3};
        v[9]  = '{1,0,1,16'd0,2'd0,0, 2'd2,0,1,0,2'd3};
        v[10] = '{0,0,0,16'd0,2'd0,0, 2'd1,1,1,0,2'd3};
        v[11] = '{0,1,0,16'd0,2'd0,0, 2'd0,0,0,0,2'd3};
        v[12] = '{0,0,0,16'd0,2'd0,0, 2'd0,0,0,0,2'd3};
        v[13] = '{1,0,0,16'd0,2'd2,0, 2'd1,1,1,0,2'd0};
        v[14] = '{0,0,0,16'd0,2'd0,1, 2'd1,1,1,0,2'd1};
        v[15] = '{0,0,0,16'd0,2'd0,1, 2'd3,0,0,1,2'd2};
        v[16] = '{1,0,0,16'd0,2'd0,0, 2'd0,0,0,0,2'd2};
        v[17] = '{0,0,0,16'd0,2'd0,1, 2'd0,0,0,0,2'd2};
        v[18] = '{1,0,0,16'd2,2'd1,0, 2'd1,0,1,0,2'd0};
        v[19] = '{0,1,1,16'd0,2'd0,0, 2'd0,0,0,0,2'd0};

        b2.start = 0; b2.stop = 0; b2.pause = 0; b2.divisor = 0; b2.target_periods = 0; b2.tc_in = 0;
        do_reset();
        chk("reset state", b1.state_o, ST_IDLE);
        chk("reset busy", b1.busy, 0);
        chk("reset periods", b1.periods_done, 0);

        for (int i = 0; i < 20; i++) begin
            b2.start = v[i].start; b2.stop = v[i].stop; b2.pause = v[i].pause;
            b2.divisor = v[i].div; b2.target_periods = v[i].tgt; b2.tc_in = v[i].tc;
            tick();
            chk($sformatf("row%0d state", i), b2.state_o, v[i].e_st);
            chk($sformatf("row%0d ena", i), b2.ena_out, v[i].e_ena);
            chk($sformatf("row%0d busy", i), b2.busy, v[i].e_busy);
            chk($sformatf("row%0d done", i), b2.done, v[i].e_done);
            chk($sformatf("row%0d periods", i), b2.periods_done, v[i].e_per);
        end
        b2.start = 0; b2.stop = 0; b2.pause = 0; b2.tc_in = 0;

        do_reset();
        go(16'd0, 8'd2);
        chk("t1 state", b1.state_o, ST_RUN);
        chk("t1 first ena", b1.ena_out, 1);
        base = ena_cnt;
        cyc = 1;
        while (!b1.done && cyc < 100) begin tick(); cyc++; end
        chk("t1 done cycle", cyc, 23);
        chk("t1 periods", b1.periods_done, 2);
        chk("t1 ena count", ena_cnt - base, 22);
        chk("t1 done ena", b1.ena_out, 0);
        tick();
        chk("t1 idle state", b1.state_o, ST_IDLE);
        chk("t1 idle busy", b1.busy, 0);
        chk("t1 idle ena", b1.ena_out, 0);
        chk("t1 idle done", b1.done, 0);

        do_reset();
        go(16'd3, 8'd1);
        base = ena_cnt; cyc = 1; first = 0; sp = 0;
        while (!b1.done && cyc < 100) begin
            if (b1.ena_out) begin
                if (first == 0) first = cyc;
                if (cyc % 4 != 0) sp++;
            end
            tick();
            cyc++;
        end
        chk("t2 first ena cycle", first, 4);
        chk("t2 spacing errors", sp, 0);
        chk("t2 done cycle", cyc, 30);
        chk("t2 ena count", ena_cnt - base, 7);
        chk("t2 periods", b1.periods_done, 1);

        do_reset();
        go(16'd3, 8'd1);
        base = ena_cnt;
        repeat (5) tick();
        b1.pause = 1'b1;
        tick();
        chk("t3 hold state", b1.state_o, ST_HOLD);
        chk("t3 hold busy", b1.busy, 1);
        first = ena_cnt; bad = 0;
        repeat (9) begin
            tick();
            if (b1.state_o != ST_HOLD || b1.ena_out) bad++;
        end
        chk("t3 hold violations", bad, 0);
        chk("t3 hold ena count", ena_cnt - first, 0);
        b1.pause = 1'b0;
        tick();
        chk("t3 resume state", b1.state_o, ST_RUN);
        chk("t3 resume ena", b1.ena_out, 0);
        tick();
        chk("t3 resume first ena", b1.ena_out, 1);
        cyc = 18;
        while (!b1.done && cyc < 100) begin tick(); cyc++; end
        chk("t3 done cycle", cyc, 40);
        chk("t3 ena count", ena_cnt - base, 7);

        do_reset();
        go(16'd0, 8'd5);
        cyc = 1;
        while (b1.periods_done != 1 && cyc < 60) begin tick(); cyc++; end
        chk("t4 first period cycle", cyc, 9);
        b1.stop = 1'b1;
        tick();
        b1.stop = 1'b0;
        chk("t4 stop state", b1.state_o, ST_IDLE);
        bad = 0;
        repeat (4) begin
            if (b1.done) bad++;
            tick();
        end
        chk("t4 no done", bad, 0);
        chk("t4 periods hold", b1.periods_done, 1);
        go(16'd0, 8'd0);
        chk("t4 restart periods", b1.periods_done, 0);
        chk("t4 restart state", b1.state_o, ST_RUN);

        cyc = 1;
        while (b1.periods_done != 1 && cyc < 60) begin tick(); cyc++; end
        chk("t6 periods before hold", b1.periods_done, 1);
        b1.pause = 1'b1;
        tick();
        chk("t6 hold state", b1.state_o, ST_HOLD);
        #2 rstna = 1'b0;
        #1;
        chk("t6 async state", b1.state_o, ST_IDLE);
        chk("t6 async busy", b1.busy, 0);
        chk("t6 async periods", b1.periods_done, 0);
        chk("t6 async ena", b1.ena_out, 0);
        chk("t6 async done", b1.done, 0);
        b1.pause = 1'b0;
        tick();
        rstna = 1'b1;
        b1.start = 1'b1; b1.stop = 1'b1; b1.divisor = 0;
        tick();
        b1.start = 1'b0; b1.stop = 1'b0;
        chk("t6 start+stop state", b1.state_o, ST_IDLE);
        chk("t6 start+stop busy", b1.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
